// File: rtl/limber_gnrl_ldarb_if.sv
// Handshake and shared-register write bundle for limber_gnrl_ldarb.
interface limber_gnrl_ldarb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IW   = 2
);
  logic               stall;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*DW-1:0] req_dat;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_rdy;
  logic               wr_lden;
  logic [DW-1:0]      wr_dnxt;
  logic [IW-1:0]      wr_gid;

  modport master (
    output stall, req_vld, req_dat, req_lock,
    input  req_rdy, wr_lden, wr_dnxt, wr_gid
  );

  modport slave (
    input  stall, req_vld, req_dat, req_lock,
    output req_rdy, wr_lden, wr_dnxt, wr_gid
  );
endinterface

// File: rtl/limber_gnrl_ldarb.sv
// Round-robin write arbiter feeding one shared lden/dnxt register.
// Optional burst locking is enabled by defining LIMBER_GNRL_LDARB_LOCK_EN.
module limber_gnrl_ldarb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned IW       = 2,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  limber_gnrl_ldarb_if.slave   bus
);

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            hi_found;
  logic            lo_found;
  logic [IW-1:0]   hi_id;
  logic [IW-1:0]   lo_id;
  logic [IW-1:0]   gid;
  logic [IW-1:0]   gid_inc;
  logic            hs;
  logic [DW-1:0]   sel_dat;

`ifdef LIMBER_GNRL_LDARB_LOCK_EN
  localparam int unsigned CW = 8;

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_inc;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] owner_mask;
  logic            owner_vld;
  logic            owner_lock;
  logic            gnt_lock;

  assign owner_mask = NREQ'(1) << owner;
  assign owner_vld  = |(bus.req_vld & owner_mask);
  assign owner_lock = |(bus.req_lock & owner_mask);
  assign gnt_lock   = |(bus.req_lock & gnt);
  assign owner_inc  = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.req_lock, 8'(LOCK_MAX)};
`endif

  // Pick the lowest eligible index at/after ptr, else the lowest below ptr.
  always_comb begin
    elig = bus.req_vld;
`ifdef LIMBER_GNRL_LDARB_LOCK_EN
    if (state == LOCKED) elig = bus.req_vld & owner_mask;
`endif
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (IW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_id    = IW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IW'(i);
        end
      end
    end
    gid = hi_found ? hi_id : lo_id;
    hs  = (hi_found | lo_found) & ~bus.stall & rst;
    gnt = hs ? (NREQ'(1) << gid) : '0;
  end

  assign bus.req_rdy = gnt;
  assign gid_inc     = (gid == IW'(NREQ - 1)) ? '0 : gid + IW'(1);

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gid == IW'(i)) sel_dat = bus.req_dat[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr         <= '0;
      bus.wr_lden <= 1'b0;
      bus.wr_dnxt <= '0;
      bus.wr_gid  <= '0;
`ifdef LIMBER_GNRL_LDARB_LOCK_EN
      state       <= IDLE;
      owner       <= '0;
      cnt         <= '0;
`endif
    end else begin
      bus.wr_lden <= hs;
      if (hs) begin
        bus.wr_dnxt <= sel_dat;
        bus.wr_gid  <= gid;
      end
`ifdef LIMBER_GNRL_LDARB_LOCK_EN
      case (state)
        IDLE: begin
          if (hs) begin
            // A one-grant burst limit means the lock never actually engages.
            if (gnt_lock && (LOCK_MAX > 1)) begin
              state <= LOCKED;
              owner <= gid;
              cnt   <= CW'(1);
            end else begin
              ptr <= gid_inc;
            end
          end
        end
        LOCKED: begin
          if (!bus.stall) begin
            if (!owner_vld || !owner_lock || (cnt + CW'(1) >= CW'(LOCK_MAX))) begin
              state <= IDLE;
              cnt   <= '0;
              ptr   <= owner_inc;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (hs) ptr <= gid_inc;
`endif
    end
  end

endmodule

// File: doc/limber_gnrl_ldarb.md
Name: limber_gnrl_ldarb

Overview:
- Round-robin write arbiter for one shared load-enabled DFF register (DFFLR-style, lden/dnxt interface).
- NREQ requesters present data with a valid/ready handshake; the block grants at most one per cycle.
- It drives registered lden/dnxt/grant-id to the shared register.
- Sits between pipeline clients (CSR writers, debug port, bus slave) and a shared state register in the Limber mcu.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data width of the shared register.
- IW, 2, grant-id width; must satisfy 2^IW >= NREQ.
- LOCK_MAX, 8, maximum consecutive grants in one lock burst (used only with the optional feature; 1..255).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  downstream hold; while 1, no grant is issued.
- req_vld  in  NREQ  per-requester write request.
- req_dat  in  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW].
- req_lock  in  NREQ  per-requester lock request (ignored without the optional feature).
- req_rdy  out  NREQ  one-hot grant; the handshake completes when req_vld[i] & req_rdy[i].
- wr_lden  out  1  load enable to the shared DFF, registered.
- wr_dnxt  out  DW  data to the shared DFF, registered.
- wr_gid  out  IW  index of the requester whose data is on wr_dnxt, registered.

Behaviour:
- Reset (rst=0 at a clk edge):
  - ptr=0; wr_lden=0; wr_dnxt=0; wr_gid=0.
  - State goes to IDLE; lock counter cleared.
  - req_rdy is forced to all-zero while rst=0.
  - Reset asserted mid-burst drops any lock, and a transfer in flight is discarded.
- Arbitration is combinational in cycle t:
  - Eligible set = req_vld (in LOCKED, only the lock owner).
  - req_rdy = one-hot of the first eligible index, searching ptr, ptr+1, …, NREQ-1, 0, … (wrap).
  - req_rdy = 0 if stall=1 or the eligible set is empty.
  - req_rdy never depends on req_rdy of another requester; there is no combinational path from req_dat.
- Pointer update:
  - On a handshake with requester g, ptr <= (g+1) mod NREQ. For non-power-of-2 NREQ, g=NREQ-1 wraps to 0.
  - With no handshake, ptr holds.
- Latency:
  - A handshake at edge t gives wr_lden=1, wr_dnxt=req_dat[g], wr_gid=g during cycle t+1. The DFF loads at edge t+2.
  - With no handshake, wr_lden=0 the next cycle, and wr_dnxt/wr_gid hold their last values.
- Throughput: one write per cycle; back-to-back grants allowed.
- With stall=1, grants are suppressed, but the already-registered wr_lden still asserts for one cycle (stall affects only new grants).
- Simultaneous events: all NREQ valid gives strict rotation 0,1,2,3,0…; a requester dropping req_vld without a handshake is legal and loses no fairness.
- States: IDLE, LOCKED.
  - Without the feature, the block stays permanently in IDLE.

Optional Feature:
- Macro: LIMBER_GNRL_LDARB_LOCK_EN.
- Defined:
  - IDLE→LOCKED on a handshake by g with req_lock[g]=1; owner=g, cnt=1. In this case ptr is not advanced.
  - In LOCKED, only the owner is eligible. Each owner handshake does cnt++.
  - LOCKED→IDLE on any of:
    - an owner handshake with req_lock=0;
    - owner req_vld=0 in a non-stall cycle;
    - cnt reaching LOCK_MAX on a handshake.
  - On release, ptr = owner+1.
  - stall in LOCKED holds the state and cnt.
- Undefined: req_lock is ignored, no counter or owner logic exists, and behaviour is pure round-robin.

Test Plan:
- Reset: drive rst=0 with req_vld=4'b1111 → req_rdy=0 and wr_lden=0/wr_dnxt=0/wr_gid=0; after rst=1 the first grant goes to req 0.
- Rotation: all four valid, req_dat = 8'h10,11,12,13, stall=0 for 8 cycles → wr_gid sequence 0,1,2,3,0,1,2,3, wr_dnxt matches, wr_lden=1 continuously from cycle 2.
- Sparse/wrap: only req 3 then req 1 valid with ptr=2 → grant 3, ptr=0, then grant 1; wr_lden is 1 exactly on the two cycles after each handshake.
- Stall: stall=1 for 3 cycles with req 2 valid → req_rdy=0 throughout, no wr_lden except the pending one; after stall=0, grant req 2 the next cycle.
- Lock (macro on, LOCK_MAX=3): req 1 holds req_lock=1 and req_vld=1 while req 0 and req 2 are also valid → grants go to req 1 three times, then req 2 (ptr=2), then req 0.
- Lock early release (macro on): req 1 lock burst, then req_vld[1]=0 after 2 grants → the next grant goes to req 2. With the macro off, the same stimulus gives plain rotation 1,2,0.
